// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin arbiter for the single regfile write port plus pending-write scoreboard for multi-cycle ops.
// Latency: accept at edge N -> RegWrite/A3/WD3 presented N..N+1; claim sets busy at edge N; req1 accept clears it at edge N.
// Backpressure: combinational ready, at most one requester accepted per cycle; the loser holds valid until granted.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int REGNUM = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [REGNUM-1:0] busy_vec,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3
);

    // Index of the requester granted on the most recent transfer.
    logic              r_last_grant;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd3;
    logic [REGNUM-1:0] r_busy;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [REGNUM-1:0] w_set;
    logic [REGNUM-1:0] w_clr;
    logic [REGNUM-1:0] w_busy_nxt;

    // Grant: a lone requester always wins; under contention the one not granted last time wins.
    always_comb begin
        w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
        w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        w_xfer = w_gnt0 || w_gnt1;
        w_addr = w_gnt1 ? req1_addr : req0_addr;
        w_data = w_gnt1 ? req1_data : req0_data;
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Scoreboard update: new claim has priority over a same-address retire; register 0 is never busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (claim_valid && (claim_addr != '0)) begin
            w_set[claim_addr] = 1'b1;
        end
        if (w_gnt1) begin
            w_clr[req1_addr] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Round-robin pointer; starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_gnt1;
        end
    end

    // Write-port register: writes to register 0 are accepted but dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_regwrite <= 1'b0;
            r_a3       <= '0;
            r_wd3      <= '0;
        end else if (w_xfer && (w_addr != '0)) begin
            r_regwrite <= 1'b1;
            r_a3       <= w_addr;
            r_wd3      <= w_data;
        end else begin
            r_regwrite <= 1'b0;
            r_a3       <= '0;
            r_wd3      <= '0;
        end
    end

    // Pending-write bitmap for multi-cycle destinations.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;
    assign RegWrite = r_regwrite;
    assign A3       = r_a3;
    assign WD3      = r_wd3;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 register file. Two writeback sources share the single regfile write port (RegWrite/A3/WD3): requester 0 is the single-cycle ALU/load path and requester 1 is the multi-cycle unit (mult/div). The block also tracks destination registers claimed by in-flight multi-cycle ops, so decode can stall on RAW hazards. It sits between the writeback sources and regfile, with busy_vec fed back to hazard/decode logic.

## Interface
- DATA_W, 32, data width of write data
- ADDR_W, 5, register address width
- REGNUM, 32, number of architectural registers (2**ADDR_W)

- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid  in  1  requester 1 has a write pending
- req1_addr  in  ADDR_W  requester 1 destination register
- req1_data  in  DATA_W  requester 1 write data
- req1_ready  out  1  requester 1 accepted this cycle (combinational)
- claim_valid  in  1  decode issued a multi-cycle op; mark claim_addr pending
- claim_addr  in  ADDR_W  destination register of the issued multi-cycle op
- busy_vec  out  REGNUM  bit i = 1: register i has a pending requester-1 write
- RegWrite  out  1  regfile write enable (registered)
- A3  out  ADDR_W  regfile write address (registered)
- WD3  out  DATA_W  regfile write data (registered)

## Operation
- Transfer on requester k occurs when reqk_valid && reqk_ready at a rising edge.
- Arbitration, per cycle, combinational from inputs and last_grant:
  - only one valid: that requester gets ready=1.
  - both valid: requester != last_grant gets ready=1 (round-robin); other ready=0.
  - neither valid: both ready=0.
- last_grant updates to the granted index on every transfer; it holds when there is no transfer.
- reqk_ready never asserts without reqk_valid, and at most one ready is high per cycle.
- Write port register, on each edge:
  - transfer with addr != 0: RegWrite<=1, A3<=addr, WD3<=data.
  - transfer with addr == 0: transfer is accepted, RegWrite<=0, A3<=0, WD3<=0 (the write is discarded).
  - no transfer: RegWrite<=0, A3<=0, WD3<=0.
- Scoreboard busy[REGNUM-1:0], on each edge:
  - claim_valid && claim_addr != 0: set busy[claim_addr].
  - requester 1 transfer: clear busy[req1_addr].
  - same address set and cleared in one edge: set wins (the new claim outstands).
  - requester 0 transfers never modify busy.
  - busy[0] is constantly 0.
- busy_vec = busy (registered, no bypass of the current-cycle claim).
- Requesters hold valid/addr/data stable until accepted; the arbiter does not check this.

## Timing
- Reset (reset=1 at an edge): RegWrite=0, A3=0, WD3=0, busy_vec=0, last_grant=1 (so requester 0 wins the first contention). reset overrides any transfer or claim in the same cycle. reqk_ready stays combinational during reset: a transfer that handshakes while reset=1 is treated as lost. Requesters must not present valid while reset=1.
- Accept-to-write latency: transfer at edge N → RegWrite/A3/WD3 valid during cycle N..N+1 → regfile writes at edge N+1.
- Claim latency: claim at edge N → busy_vec bit high from edge N.
- Retire latency: requester 1 transfer at edge N → busy bit low from edge N. This is the same cycle RegWrite is presented. Regfile read data becomes correct after edge N+1, so decode must add one stall cycle or forward WD3.
- Throughput: one write per cycle. Under continuous contention, grants alternate 0,1,0,1…

## Test plan
- Reset: hold reset 2 cycles with req0_valid=req1_valid=claim_valid=1 → after release, RegWrite=0, busy_vec=0. The first contention cycle grants requester 0.
- Single requester: req0 addr=5 data=0xDEADBEEF for 1 cycle → req0_ready=1 that cycle. Next cycle RegWrite=1, A3=5, WD3=0xDEADBEEF; the following cycle RegWrite=0.
- Contention: both valid for 4 cycles (req0 addr=3, req1 addr=7) → grant order 0,1,0,1. RegWrite stays continuously 1 with A3 sequence 3,7,3,7.
- Scoreboard: claim addr=9 → busy_vec[9]=1 from the next edge. A req1 transfer to addr 9 clears the bit, while a req0 transfer to addr 9 leaves it at 1. In the same edge, a claim of 9 together with a req1 retire of 9 leaves busy_vec[9]=1.
- Register zero: req1 transfer addr=0, and claim addr=0 → ready=1 but RegWrite=0, A3=0, WD3=0. busy_vec stays 0.
- Reset mid-operation: busy_vec=0x0000_0600 with RegWrite=1 pending, then assert reset → the next edge gives busy_vec=0 and RegWrite=0. Round-robin restarts with requester 0 preferred.
